// File: rtl/rpn_stack_controller_if.sv
// Signal bundle between the front end, the ALU, the display selector and rpn_stack_controller.
// slave is the controller's view; master is the surrounding system's view.
interface rpn_stack_controller_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             enter_pulse;
    logic             op_mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] data_out;
    logic [3:0]       flags;
    logic [DW-1:0]    depth;
    logic             busy;
    logic             error;
    logic [3:0]       current_state;

    modport master (
        output enter_pulse, op_mode, data_in, alu_result, alu_flags,
        input  alu_a, alu_b, alu_op, data_out, flags, depth, busy, error, current_state
    );

    modport slave (
        input  enter_pulse, op_mode, data_in, alu_result, alu_flags,
        output alu_a, alu_b, alu_op, data_out, flags, depth, busy, error, current_state
    );
endinterface

// File: rtl/rpn_stack_controller.sv
// Reverse-Polish stack sequencer in front of the shared calculator ALU.
// Optional macro RPN_CTRL_DUP_EN turns opcode 6 into DUP (copy top of stack).
module rpn_stack_controller #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    rpn_stack_controller_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] OP_CLEAR = 3'd7;
`ifdef RPN_CTRL_DUP_EN
    localparam logic [2:0] OP_DUP = 3'd6;
`endif

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PUSH  = 4'd1,
        FETCH = 4'd2,
        EXEC  = 4'd3,
        WRITE = 4'd4,
        ERR   = 4'd5
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [DW-1:0]    depth;
    logic [WIDTH-1:0] operand;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] result;
    logic [3:0]       res_flags;
    logic [3:0]       flags;
    logic             error;
    logic [AW-1:0]    idx_push;
    logic [AW-1:0]    idx_top;
    logic [AW-1:0]    idx_second;
    logic [WIDTH-1:0] top;

    assign idx_push   = AW'(depth);
    assign idx_top    = AW'(depth - DW'(1));
    assign idx_second = AW'(depth - DW'(2));
    assign top        = (depth == '0) ? '0 : stack[idx_top];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            depth     <= '0;
            flags     <= '0;
            error     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            operand   <= '0;
            opcode    <= '0;
            result    <= '0;
            res_flags <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.enter_pulse) begin
                        operand <= bus.data_in;
                        opcode  <= bus.data_in[2:0];
                        if (!bus.op_mode) begin
                            if (depth == DW'(DEPTH)) begin
                                state <= ERR;
                                error <= 1'b1;
                            end else begin
                                state <= PUSH;
                            end
                        end else if (bus.data_in[2:0] == OP_CLEAR) begin
                            depth <= '0;
                            flags <= '0;
`ifdef RPN_CTRL_DUP_EN
                        end else if (bus.data_in[2:0] == OP_DUP) begin
                            // DUP reuses the PUSH path with the current top as operand.
                            operand <= top;
                            if (depth != '0 && depth != DW'(DEPTH)) begin
                                state <= PUSH;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
`endif
                        end else if (depth < DW'(2)) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                PUSH: begin
                    stack[idx_push] <= operand;
                    depth           <= depth + DW'(1);
                    state           <= IDLE;
                end
                FETCH: begin
                    alu_a  <= stack[idx_second];
                    alu_b  <= stack[idx_top];
                    alu_op <= opcode;
                    state  <= EXEC;
                end
                EXEC: begin
                    result    <= bus.alu_result;
                    res_flags <= bus.alu_flags;
                    state     <= WRITE;
                end
                WRITE: begin
                    stack[idx_second] <= result;
                    depth             <= depth - DW'(1);
                    flags             <= res_flags;
                    state             <= IDLE;
                end
                ERR: begin
                    if (bus.enter_pulse) begin
                        error <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_a         = alu_a;
    assign bus.alu_b         = alu_b;
    assign bus.alu_op        = alu_op;
    assign bus.data_out      = top;
    assign bus.flags         = flags;
    assign bus.depth         = depth;
    assign bus.error         = error;
    assign bus.current_state = state;
    assign bus.busy          = (state != IDLE) && (state != ERR);
endmodule

// File: doc/rpn_stack_controller.md
Name: rpn_stack_controller

Overview:
Sequencer that turns the calculator ALU into a reverse-Polish stack machine. It holds a DEPTH-entry operand stack and accepts one debounced Enter pulse per operand or operator. For binary operators it pops two operands, drives the shared ALU, and pushes the result back. It sits between the debouncer/synchronizer front end and the ALU, and feeds the display selector with the top of stack.

Parameters:
WIDTH, 16, operand/result width in bits
DEPTH, 4, stack entries (must be >=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enter_pulse  input  1  single-cycle debounced Enter
op_mode  input  1  1 = data_in[2:0] is an opcode; 0 = data_in is an operand
data_in  input  WIDTH  operand or opcode
alu_a  output  WIDTH  ALU operand A (second from top)
alu_b  output  WIDTH  ALU operand B (top)
alu_op  output  3  ALU opcode
alu_result  input  WIDTH  combinational ALU result
alu_flags  input  4  combinational ALU flags {N,Z,C,V}
data_out  output  WIDTH  top of stack; 0 when empty
flags  output  4  registered {N,Z,C,V} of the last completed operation
depth  output  $clog2(DEPTH+1)  current stack occupancy
busy  output  1  high in any state other than IDLE or ERR
error  output  1  sticky overflow/underflow indicator
current_state  output  4  state encoding for LEDs

Behaviour:
- Single clock domain. Reset is synchronous and active-high, named clk/reset.
- Reset values: state=IDLE, depth=0, data_out=0, flags=0, error=0, alu_a/alu_b/alu_op=0. Stack contents do not need reset.
- State encoding: IDLE=0, PUSH=1, FETCH=2, EXEC=3, WRITE=4, ERR=5.
- Accept cycle: in IDLE, enter_pulse latches data_in and op_mode into internal registers. Pulses in PUSH/FETCH/EXEC/WRITE are ignored and not queued.
- IDLE, operand (op_mode=0):
  - depth==DEPTH -> ERR (overflow).
  - Otherwise -> PUSH.
- IDLE, opcode (op_mode=1):
  - opcode 7 (CLEAR): depth<=0, flags<=0, stay IDLE. Legal at any depth.
  - Any other opcode with depth<2 -> ERR (underflow).
  - Otherwise -> FETCH.
- PUSH: stack[depth]<=operand, depth<=depth+1, -> IDLE. data_out shows the new value 2 cycles after the enter cycle.
- FETCH: register alu_a=stack[depth-2], alu_b=stack[depth-1], alu_op=opcode; -> EXEC.
- EXEC: ALU inputs are stable; capture alu_result and alu_flags into internal registers; -> WRITE.
- WRITE: stack[depth-2]<=result, depth<=depth-1, flags<=captured flags; -> IDLE.
- Operator latency: the result appears on data_out 4 cycles after the enter cycle.
- busy is high from the cycle after acceptance through WRITE.
- ERR: error=1; stack, depth, and flags are unchanged. The next enter_pulse clears error and returns to IDLE. That pulse's data is discarded.
- data_out is always stack[depth-1], or 0 when depth==0.
- Arithmetic: the controller does no arithmetic. The result is truncated to WIDTH by the ALU; the controller stores it as-is.
- Reset asserted in any state, including mid-operation, wins. The next cycle matches the reset values, and a partially executed operation leaves no stack or flag update.

Optional Feature:
Macro RPN_CTRL_DUP_EN.
- Defined: opcode 6 = DUP.
  - Requires 1<=depth<DEPTH; otherwise -> ERR.
  - Executes through PUSH with operand=stack[depth-1]. No ALU access; flags unchanged.
- Undefined: opcode 6 is an ordinary binary ALU opcode, identical to 0–5.

Test Plan:
1. WIDTH=16, DEPTH=4, bench ALU (op0=add, op1=sub). Push 5, push 3, opcode 0 -> data_out=8, depth=1, flags=4'b0000. data_out changes exactly 4 cycles after the op enter.
2. Push 7, push 7, opcode 1 -> data_out=0, flags=4'b0100, depth=1.
3. Push 1,2,3,4 then push 9 -> state=ERR, error=1, depth=4, data_out=4. Next enter -> IDLE, error=0, depth=4.
4. Depth=1 with opcode 0 -> ERR, depth=1 unchanged. Then opcode 7 after recovery -> depth=0, data_out=0, flags=0.
5. Enter pulse during FETCH/EXEC is ignored, so depth changes once. Reset asserted in EXEC -> next cycle depth=0, state=0, flags=0, no WRITE.
6. RPN_CTRL_DUP_EN defined: push 0x1234, opcode 6 -> depth=2, data_out=0x1234. Undefined: same sequence -> ERR (underflow).
